spi_burst_command_handler: RTL and testbench
============================================

Name: spi_burst_command_handler

Overview:
Parametrised burst sequencer for register access to BMP280-class SPI sensors on multiple chip selects. It accepts one command (read/write, target, start address, byte count) and sequences a byte-level SPI shifter. It owns the chip selects and holds the selected one low across the whole burst. It sits between the sensor control FSM and the byte shifter, replacing single-byte command execution with multi-byte bursts.

Parameters:
PACKAGE_SIZE, 8, SPI byte width; the address field is PACKAGE_SIZE-1 bits and the MSB is the R/W flag.
MAX_BURST, 8, maximum data bytes per command (>=1).
NUM_CS, 2, number of chip-select outputs (>=1).
CS_GUARD, 2, clk cycles csb is held low before the first byte and after the last byte (>=1).

Ports:
clk  in  1  system clock.
rstb  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high when a command can be accepted.
cmd_rw  in  1  1 = read, 0 = write.
cmd_cs  in  max(1,clog2(NUM_CS))  target chip-select index.
cmd_addr  in  PACKAGE_SIZE-1  start register address.
cmd_len  in  clog2(MAX_BURST+1)  data byte count.
wr_data  in  MAX_BURST*PACKAGE_SIZE  write bytes; byte k is bits [k*PACKAGE_SIZE +: PACKAGE_SIZE].
rd_data  out  MAX_BURST*PACKAGE_SIZE  read bytes, same packing.
rd_valid  out  1  one-cycle pulse at command completion (read and write).
error  out  1  one-cycle pulse when a command is rejected.
busy  out  1  high whenever the block is not IDLE.
csb  out  NUM_CS  active-low chip selects.
spi_send  out  1  one-cycle byte start strobe to the shifter.
spi_tx  out  PACKAGE_SIZE  byte to shift out.
spi_busy  in  1  shifter busy.
spi_done  in  1  one-cycle pulse when a byte has been exchanged.
spi_rx  in  PACKAGE_SIZE  received byte, valid with spi_done.

Behaviour:
- Reset values (asynchronous, active immediately): csb all ones; spi_send, rd_valid, error, busy = 0; cmd_ready = 1; spi_tx, rd_data = 0; FSM in IDLE. A reset during a burst releases csb in the same instant; no partial result is reported.
- cmd_ready = (state==IDLE). A command is accepted on a clk edge where cmd_valid && cmd_ready. On acceptance, all cmd_* fields and wr_data are latched.
- Rejection: cmd_len==0, cmd_len>MAX_BURST, or cmd_cs>=NUM_CS. The block pulses error in the next cycle, stays in IDLE, and leaves csb and rd_data untouched.
- States:
  - IDLE -> CS_SETUP on a valid accept.
  - CS_SETUP: csb[cs]=0 for CS_GUARD cycles, then -> ADDR.
  - ADDR: when spi_busy==0, pulse spi_send for one cycle with spi_tx={cmd_rw,addr}. On spi_done -> DATA.
  - DATA: send one byte per spi_done. A read sends 0x00 and stores spi_rx into byte index idx. A write sends wr_data byte idx.
  - Write bursts use address/data pairs: after every data byte except the last, return to ADDR with addr+1, wrapping modulo 2^(PACKAGE_SIZE-1).
  - Read bursts use a single address byte; the sensor auto-increments.
  - After byte cmd_len-1 -> CS_HOLD: csb stays low for CS_GUARD cycles, then goes all ones -> DONE.
  - DONE: rd_valid=1 for one cycle -> IDLE.
- spi_send is never asserted while spi_busy=1 or while a byte is outstanding. Exactly one spi_done is consumed per spi_send.
- rd_data: cleared to 0 on accept of a read; bytes idx>=cmd_len stay 0. It holds its value until the next accepted read. Writes do not modify rd_data.
- Only the selected csb bit goes low; all other bits stay high throughout.
- cmd_valid while busy is ignored, with no queuing.
- A spi_done that arrives in IDLE, CS_SETUP or CS_HOLD is ignored.
- Byte counts:
  - Read: 1+cmd_len bytes on the wire.
  - Write: 2*cmd_len bytes on the wire.

Test Plan:
- Read, cs=0, addr=0x7A, len=3; shifter model returns 0x11,0x22,0x33 on the data bytes -> wire shows 0xFA,0x00,0x00,0x00; rd_data[23:0]=0x332211, upper bytes 0; rd_valid pulses once; csb[0] low continuously; csb[1] stays high.
- Write, cs=1, addr=0x74, len=2, wr_data[15:0]=0x5727 -> wire shows 0x74,0x27,0x75,0x57; rd_data unchanged; csb[1] low for the whole burst.
- Rejection: len=0, then len=MAX_BURST+1, then cs=NUM_CS -> error pulses once per command; csb never drops; cmd_ready stays 1.
- Wrap-around: write, addr=0x7F, len=2 -> address bytes 0x7F then 0x00.
- Guard timing: measure cycles from csb falling edge to the first spi_send, and from the last spi_done to csb rising edge -> both >= CS_GUARD. A cmd_valid issued mid-burst is ignored.
- Reset mid-read after 1 of 4 bytes -> csb all ones asynchronously and busy=0. A following read of len=1 completes normally with rd_data cleared except byte 0.

Source files
------------

// File: rtl/spi_burst_command_handler_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_command_handler_if
// Purpose  : Command-side and byte-shifter-side signals of the burst handler.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_burst_command_handler_if #(
    parameter int PACKAGE_SIZE = 8,
    parameter int MAX_BURST    = 8,
    parameter int NUM_CS       = 2
);
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int LEN_W = $clog2(MAX_BURST + 1);

    logic                              cmd_valid;
    logic                              cmd_ready;
    logic                              cmd_rw;
    logic [CS_W-1:0]                   cmd_cs;
    logic [PACKAGE_SIZE-2:0]           cmd_addr;
    logic [LEN_W-1:0]                  cmd_len;
    logic [MAX_BURST*PACKAGE_SIZE-1:0] wr_data;
    logic [MAX_BURST*PACKAGE_SIZE-1:0] rd_data;
    logic                              rd_valid;
    logic                              error;
    logic                              busy;
    logic [NUM_CS-1:0]                 csb;
    logic                              spi_send;
    logic [PACKAGE_SIZE-1:0]           spi_tx;
    logic                              spi_busy;
    logic                              spi_done;
    logic [PACKAGE_SIZE-1:0]           spi_rx;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_cs, cmd_addr, cmd_len, wr_data,
        input  spi_busy, spi_done, spi_rx,
        output cmd_ready, rd_data, rd_valid, error, busy, csb, spi_send, spi_tx
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_cs, cmd_addr, cmd_len, wr_data,
        output spi_busy, spi_done, spi_rx,
        input  cmd_ready, rd_data, rd_valid, error, busy, csb, spi_send, spi_tx
    );
endinterface
`default_nettype wire

// File: rtl/spi_burst_command_handler.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_command_handler
// Purpose  : Multi-byte SPI register burst sequencer driving a byte shifter.
// Revision : 1.0 - initial release
// ============================================================================
module spi_burst_command_handler #(
    parameter int PACKAGE_SIZE = 8,
    parameter int MAX_BURST    = 8,
    parameter int NUM_CS       = 2,
    parameter int CS_GUARD     = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rstb,
    spi_burst_command_handler_if.slave bus
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int LEN_W  = $clog2(MAX_BURST + 1);
    localparam int ADDR_W = PACKAGE_SIZE - 1;
    localparam int GD_W   = $clog2(CS_GUARD + 1);
    localparam int DATA_W = MAX_BURST * PACKAGE_SIZE;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_addr  = 3'd2;
    localparam logic [2:0] c_st_data  = 3'd3;
    localparam logic [2:0] c_st_hold  = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [GD_W-1:0] c_guard_last = GD_W'(CS_GUARD - 1);

    logic [2:0]              r_state;
    logic [2:0]              w_next;
    logic                    r_rw;
    logic [CS_W-1:0]         r_cs;
    logic [ADDR_W-1:0]       r_addr;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_idx;
    logic [DATA_W-1:0]       r_wr_data;
    logic [DATA_W-1:0]       r_rd_data;
    logic [GD_W-1:0]         r_gcnt;
    logic                    r_pending;
    logic                    r_send;
    logic                    r_error;
    logic [PACKAGE_SIZE-1:0] r_tx;

    logic                    w_accept;
    logic                    w_cmd_ok;
    logic                    w_in_byte;
    logic                    w_issue;
    logic                    w_byte_done;
    logic                    w_last;
    logic                    w_guard_end;
    logic [NUM_CS-1:0]       w_csb;
    logic                    w_ready;
    logic                    w_busy;
    logic                    w_rd_valid;

    assign w_accept    = bus.cmd_valid && (r_state == c_st_idle);
    assign w_cmd_ok    = (int'(bus.cmd_len) != 0) && (int'(bus.cmd_len) <= MAX_BURST)
                         && (int'(bus.cmd_cs) < NUM_CS);
    assign w_in_byte   = (r_state == c_st_addr) || (r_state == c_st_data);
    // r_pending guarantees exactly one spi_done is consumed per spi_send
    assign w_issue     = w_in_byte && !r_pending && !bus.spi_busy;
    assign w_byte_done = w_in_byte && r_pending && bus.spi_done;
    assign w_last      = (r_idx + LEN_W'(1)) == r_len;
    assign w_guard_end = (r_gcnt == c_guard_last);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_accept && w_cmd_ok) w_next = c_st_setup;
            c_st_setup: if (w_guard_end) w_next = c_st_addr;
            c_st_addr:  if (w_byte_done) w_next = c_st_data;
            c_st_data: begin
                if (w_byte_done) begin
                    if (w_last) begin
                        w_next = c_st_hold;
                    end else if (!r_rw) begin
                        w_next = c_st_addr;
                    end
                end
            end
            c_st_hold:  if (w_guard_end) w_next = c_st_done;
            c_st_done:  w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_csb      = '1;
        w_ready    = 1'b0;
        w_busy     = 1'b1;
        w_rd_valid = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
            c_st_setup, c_st_addr, c_st_data, c_st_hold: w_csb[r_cs] = 1'b0;
            c_st_done: w_rd_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rw      <= 1'b0;
            r_cs      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_wr_data <= '0;
            r_rd_data <= '0;
            r_gcnt    <= '0;
            r_pending <= 1'b0;
            r_send    <= 1'b0;
            r_error   <= 1'b0;
            r_tx      <= '0;
        end else begin
            r_send  <= 1'b0;
            r_error <= 1'b0;

            if (w_accept) begin
                if (w_cmd_ok) begin
                    r_rw      <= bus.cmd_rw;
                    r_cs      <= bus.cmd_cs;
                    r_addr    <= bus.cmd_addr;
                    r_len     <= bus.cmd_len;
                    r_wr_data <= bus.wr_data;
                    r_idx     <= '0;
                    if (bus.cmd_rw) begin
                        r_rd_data <= '0;
                    end
                end else begin
                    r_error <= 1'b1;
                end
            end

            if (((r_state == c_st_setup) || (r_state == c_st_hold)) && !w_guard_end) begin
                r_gcnt <= r_gcnt + GD_W'(1);
            end else begin
                r_gcnt <= '0;
            end

            if (w_issue) begin
                r_send    <= 1'b1;
                r_pending <= 1'b1;
                if (r_state == c_st_addr) begin
                    r_tx <= {r_rw, r_addr};
                end else if (r_rw) begin
                    r_tx <= '0;
                end else begin
                    r_tx <= r_wr_data[r_idx*PACKAGE_SIZE +: PACKAGE_SIZE];
                end
            end

            if (w_byte_done) begin
                r_pending <= 1'b0;
                if (r_state == c_st_data) begin
                    if (r_rw) begin
                        r_rd_data[r_idx*PACKAGE_SIZE +: PACKAGE_SIZE] <= bus.spi_rx;
                    end
                    // Writes re-address every byte; the address wraps naturally
                    if (!w_last) begin
                        r_idx <= r_idx + LEN_W'(1);
                        if (!r_rw) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.busy      = w_busy;
    assign bus.rd_valid  = w_rd_valid;
    assign bus.csb       = w_csb;
    assign bus.error     = r_error;
    assign bus.spi_send  = r_send;
    assign bus.spi_tx    = r_tx;
    assign bus.rd_data   = r_rd_data;
endmodule
`default_nettype wire

// File: tb/tb_spi_burst_command_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_command_handler
// Purpose  : Self-checking bench: vector table, reset corner case, random bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_burst_command_handler;
    localparam int PS    = 8;
    localparam int MB    = 8;
    localparam int NCS   = 3;
    localparam int GUARD = 2;

    typedef struct {
        logic         rw;
        logic [1:0]   cs;
        logic [6:0]   addr;
        logic [3:0]   len;
        logic [63:0]  wd;
        logic [63:0]  rx;
        bit           err;
        int           n;
        logic [127:0] wire_b;
        logic [63:0]  rd;
    } vec_t;

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    spi_burst_command_handler_if #(.PACKAGE_SIZE(PS), .MAX_BURST(MB), .NUM_CS(NCS)) bus();

    spi_burst_command_handler #(
        .PACKAGE_SIZE(PS), .MAX_BURST(MB), .NUM_CS(NCS), .CS_GUARD(GUARD)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int cyc = 0, n_err = 0, n_val = 0, n_fall = 0, n_badcs = 0, n_proto = 0;
    int min_setup = 1000, min_hold = 1000, fall_t = 0, done_t = 0;
    bit wait_send = 0;
    logic [2:0] prev_csb = 3'b111;
    int cur_cs = 0;

    int nwire = 0, done_cnt = 0, sh_left = 0;
    bit sh_active = 0;
    logic [127:0] wire_cap = '0;
    logic [63:0]  cur_rx = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lo);
        total++;
        if (act < lo) begin
            bad++;
            $display("FAIL %s: got %0d expected >= %0d", name, act, lo);
        end
    endtask

    // Reference: what the wire and rd_data must show, from the command alone
    function automatic vec_t predict(input vec_t v, input logic [63:0] rd_now);
        vec_t r = v;
        int a;
        r.err    = (v.len == 0) || (int'(v.len) > MB) || (int'(v.cs) >= NCS);
        r.n      = 0;
        r.wire_b = '0;
        r.rd     = rd_now;
        if (!r.err) begin
            if (v.rw) begin
                r.wire_b[7:0] = {1'b1, v.addr};
                r.n  = 1 + int'(v.len);
                r.rd = '0;
                for (int k = 0; k < int'(v.len); k++) r.rd[k*8 +: 8] = v.rx[k*8 +: 8];
            end else begin
                r.n = 2 * int'(v.len);
                for (int k = 0; k < int'(v.len); k++) begin
                    a = (int'(v.addr) + k) % 128;
                    r.wire_b[16*k +: 8]   = 8'(a);
                    r.wire_b[16*k+8 +: 8] = v.wd[k*8 +: 8];
                end
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(logic rw, logic [1:0] cs, logic [6:0] a, logic [3:0] len,
                                logic [63:0] wd, logic [63:0] rx, bit err, int n,
                                logic [127:0] w, logic [63:0] rd);
        vec_t v;
        v.rw = rw; v.cs = cs; v.addr = a; v.len = len; v.wd = wd; v.rx = rx;
        v.err = err; v.n = n; v.wire_b = w; v.rd = rd;
        return v;
    endfunction

    // Byte shifter model: variable latency, returns cur_rx bytes on data bytes
    initial begin
        bus.spi_busy = 1'b0;
        bus.spi_done = 1'b0;
        bus.spi_rx   = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.spi_done = 1'b0;
            if (bus.spi_send) begin
                if (sh_active) n_proto++;
                if (nwire < 16) wire_cap[nwire*8 +: 8] = bus.spi_tx;
                nwire++;
                sh_active = 1'b1;
                sh_left   = $urandom_range(1, 4);
            end else if (sh_active) begin
                sh_left--;
                if (sh_left == 0) begin
                    sh_active    = 1'b0;
                    bus.spi_done = 1'b1;
                    done_cnt++;
                    bus.spi_rx = (nwire >= 2 && nwire <= 9) ? cur_rx[(nwire-2)*8 +: 8] : 8'h5A;
                end
            end
            bus.spi_busy = sh_active;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rstb) begin
            if (bus.error) n_err++;
            if (bus.rd_valid) n_val++;
            if (bus.csb != 3'b111) begin
                if (bus.csb != ~(3'b001 << cur_cs)) n_badcs++;
                if (prev_csb == 3'b111) begin
                    n_fall++;
                    fall_t    = cyc;
                    wait_send = 1'b1;
                end
            end else if (prev_csb != 3'b111) begin
                if (cyc - done_t < min_hold) min_hold = cyc - done_t;
            end
            if (bus.spi_send && wait_send) begin
                if (cyc - fall_t < min_setup) min_setup = cyc - fall_t;
                wait_send = 1'b0;
            end
            if (bus.spi_done) done_t = cyc;
        end
        prev_csb = bus.csb;
    end

    task automatic run_cmd(input string tag, input vec_t v, input bit poke);
        int t;
        @(negedge clk);
        n_err = 0; n_val = 0; n_fall = 0; n_badcs = 0; n_proto = 0;
        min_setup = 1000; min_hold = 1000; wait_send = 1'b0;
        nwire = 0; wire_cap = '0; cur_rx = v.rx; cur_cs = int'(v.cs);
        chk({tag, ".ready_before"}, bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1; bus.cmd_rw = v.rw; bus.cmd_cs = v.cs;
        bus.cmd_addr = v.addr; bus.cmd_len = v.len; bus.wr_data = v.wd;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (poke && !v.err) begin
            repeat (3) @(negedge clk);
            bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_cs = 2'd0;
            bus.cmd_addr = 7'h33; bus.cmd_len = 4'd1;
            repeat (2) @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        t = 0;
        while (n_err == 0 && n_val == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 2000) begin
            bad++;
            $display("FAIL %s.timeout: got no completion after %0d cycles expected completion", tag, t);
        end
        repeat (6) @(negedge clk);
        chk({tag, ".error_pulses"}, n_err, v.err ? 1 : 0);
        chk({tag, ".rd_valid_pulses"}, n_val, v.err ? 0 : 1);
        chk({tag, ".wire_bytes"}, nwire, v.n);
        chk({tag, ".wire_data"}, wire_cap, v.wire_b);
        chk({tag, ".rd_data"}, bus.rd_data, v.rd);
        chk({tag, ".csb_other_bits"}, n_badcs, 0);
        chk({tag, ".send_while_busy"}, n_proto, 0);
        chk({tag, ".csb_falls"}, n_fall, v.err ? 0 : 1);
        chk({tag, ".ready_after"}, bus.cmd_ready, 1'b1);
        chk({tag, ".busy_after"}, bus.busy, 1'b0);
        if (!v.err) begin
            chk_ge({tag, ".setup_guard"}, min_setup, GUARD);
            chk_ge({tag, ".hold_guard"}, min_hold, GUARD);
        end
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        logic [63:0] rd_model;
        int t;

        bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_cs = '0;
        bus.cmd_addr = '0; bus.cmd_len = '0; bus.wr_data = '0;

        #2 rstb = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.csb", bus.csb, 3'b111);
        chk("reset.cmd_ready", bus.cmd_ready, 1'b1);
        chk("reset.busy", bus.busy, 1'b0);
        chk("reset.spi_send", bus.spi_send, 1'b0);
        chk("reset.rd_valid", bus.rd_valid, 1'b0);
        chk("reset.error", bus.error, 1'b0);
        chk("reset.rd_data", bus.rd_data, 64'h0);
        chk("reset.spi_tx", bus.spi_tx, 8'h00);
        rstb = 1'b1;

        tbl[0] = mk(1'b1, 2'd0, 7'h7A, 4'd3, 64'h0, 64'h332211, 1'b0, 4, 128'hFA, 64'h332211);
        tbl[1] = mk(1'b0, 2'd1, 7'h74, 4'd2, 64'h5727, 64'h0, 1'b0, 4, 128'h57752774, 64'h332211);
        tbl[2] = mk(1'b0, 2'd0, 7'h10, 4'd0, 64'h0, 64'h0, 1'b1, 0, 128'h0, 64'h332211);
        tbl[3] = mk(1'b1, 2'd0, 7'h10, 4'd9, 64'h0, 64'h0, 1'b1, 0, 128'h0, 64'h332211);
        tbl[4] = mk(1'b1, 2'd3, 7'h10, 4'd1, 64'h0, 64'h0, 1'b1, 0, 128'h0, 64'h332211);
        tbl[5] = mk(1'b0, 2'd2, 7'h7F, 4'd2, 64'hBBAA, 64'h0, 1'b0, 4, 128'hBB00AA7F, 64'h332211);
        tbl[6] = mk(1'b1, 2'd2, 7'h10, 4'd8, 64'h0, 64'h8877665544332211, 1'b0, 9, 128'h90,
                    64'h8877665544332211);
        tbl[7] = mk(1'b1, 2'd1, 7'h00, 4'd1, 64'h0, 64'hCDAB, 1'b0, 2, 128'h80, 64'hAB);
        for (int i = 0; i < 8; i++) run_cmd($sformatf("tbl%0d", i), tbl[i], 1'b1);

        // Reset in the middle of a 4-byte read, right after the first data byte
        @(negedge clk);
        nwire = 0; wire_cap = '0; done_cnt = 0; cur_rx = 64'h44332211; cur_cs = 1; n_val = 0;
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_cs = 2'd1;
        bus.cmd_addr = 7'h05; bus.cmd_len = 4'd4;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        t = 0;
        while (done_cnt < 2 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        total++;
        if (t >= 2000) begin
            bad++;
            $display("FAIL midreset.timeout: got %0d byte completions expected 2", done_cnt);
        end
        #3 rstb = 1'b0;
        #1;
        chk("midreset.csb", bus.csb, 3'b111);
        chk("midreset.busy", bus.busy, 1'b0);
        chk("midreset.cmd_ready", bus.cmd_ready, 1'b1);
        chk("midreset.spi_send", bus.spi_send, 1'b0);
        chk("midreset.rd_data", bus.rd_data, 64'h0);
        repeat (3) @(negedge clk);
        chk("midreset.no_rd_valid", n_val, 0);
        rstb = 1'b1;
        repeat (10) @(negedge clk);
        run_cmd("post_reset", mk(1'b1, 2'd0, 7'h22, 4'd1, 64'h0, 64'hCCBBAA77, 1'b0, 2,
                                 128'hA2, 64'h77), 1'b0);
        rd_model = 64'h77;

        for (int i = 0; i < 24; i++) begin
            v.rw   = 1'($urandom_range(0, 1));
            v.cs   = 2'($urandom_range(0, 3));
            v.addr = 7'($urandom);
            v.len  = 4'($urandom_range(0, 9));
            v.wd   = {$urandom, $urandom};
            v.rx   = {$urandom, $urandom};
            v = predict(v, rd_model);
            run_cmd($sformatf("rnd%0d", i), v, 1'($urandom_range(0, 1)));
            rd_model = v.rd;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
